// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared widths, stage record and round/saturate helper for the DCT datapath
//
// Purpose : common definitions for dct_mac_pipe and the zigzag quantiser.
// Contents: prod_w/acc_w width functions, mac_stage_t stage record,
//           round_sat() scaling helper (evaluated at RS_W bits, callers truncate).
package dct_pkg;

    // Working width of the scaling helper; every accumulator fed to it must be narrower.
    localparam int RS_W = 64;

    localparam logic signed [RS_W-1:0] RS_ONE = 64'sd1;

    function automatic int prod_w(input int din_w, input int coef_w);
        return din_w + coef_w;
    endfunction

    // Growth of $clog2(taps) bits makes the dot product overflow-free.
    function automatic int acc_w(input int p_w, input int taps);
        return p_w + $clog2(taps);
    endfunction

    // Generic multiply-stage record; prod is carried sign-extended to RS_W.
    typedef struct packed {
        logic                   valid;
        logic                   first;
        logic                   last;
        logic signed [RS_W-1:0] prod;
    } mac_stage_t;

    // Round-half-up arithmetic right shift by frac, then clamp (sat_en != 0)
    // or wrap to out_w bits. The result is sign-extended to RS_W.
    function automatic logic signed [RS_W-1:0] round_sat(
        input logic signed [RS_W-1:0] sum,
        input int                     frac,
        input int                     out_w,
        input int                     sat_en
    );
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] max_v;
        logic signed [RS_W-1:0] min_v;
        r = sum;
        if (frac > 0) begin
            r = sum + (RS_ONE <<< (frac - 1));
            r = r >>> frac;
        end
        max_v = (RS_ONE <<< (out_w - 1)) - RS_ONE;
        min_v = -(RS_ONE <<< (out_w - 1));
        if (sat_en != 0) begin
            if (r > max_v) begin
                r = max_v;
            end else if (r < min_v) begin
                r = min_v;
            end
        end else begin
            // Keep the low out_w bits, re-interpreted as signed.
            r = (r <<< (RS_W - out_w)) >>> (RS_W - out_w);
        end
        return r;
    endfunction

endpackage

// File: rtl/dct_round_sat.sv
// rtl/dct_round_sat.sv - combinational round/saturate scaler for DCT results
//
// Purpose: scales a signed IN_W sum to a signed OUT_W result via round_sat().
// Ports  : sum_i  in  IN_W   signed full-precision sum
//          res_o  out OUT_W  signed rounded, shifted, clamped/wrapped result
module dct_round_sat
    import dct_pkg::*;
#(
    parameter int IN_W   = 23,
    parameter int OUT_W  = 12,
    parameter int FRAC   = 0,
    parameter int SAT_EN = 1
) (
    input  logic signed [IN_W-1:0]  sum_i,
    output logic signed [OUT_W-1:0] res_o
);

    logic signed [RS_W-1:0] sum_ext;

    assign sum_ext = {{(RS_W-IN_W){sum_i[IN_W-1]}}, sum_i};
    assign res_o   = OUT_W'(round_sat(sum_ext, FRAC, OUT_W, SAT_EN));

endmodule

// File: rtl/dct_mac_pipe.sv
// rtl/dct_mac_pipe.sv - pipelined signed multiply-accumulate, one DCT coefficient per block
//
// Purpose: dot product of TAPS (din, coef) pairs, scaled by dct_round_sat and
//          presented once per block with valid/ready flow control.
// Ports  : clk, rst (async, active-high), flush (sync abort of the partial block)
//          in_valid/in_ready/din/coef      sample/coefficient input handshake
//          out_valid/out_ready/out_data    scaled result output handshake
//          busy                            a block is partially or fully in flight
// Pipe   : stage 1 mult_res, stage 2 acc, output register; last accept at edge t
//          gives out_valid after edge t+2.
module dct_mac_pipe
    import dct_pkg::*;
#(
    parameter int DIN_W  = 8,
    parameter int COEF_W = 12,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 12,
    parameter int FRAC   = 0,
    parameter int SAT_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DIN_W-1:0]  din,
    input  logic signed [COEF_W-1:0] coef,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     busy
);

    localparam int PROD_W = prod_w(DIN_W, COEF_W);
    localparam int ACC_W  = acc_w(PROD_W, TAPS);
    localparam int CNT_W  = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic                     en;
    logic                     accept;
    logic                     load;
    logic                     tap_first;
    logic                     tap_last;
    logic [CNT_W-1:0]         tap_cnt_q;
    logic [CNT_W-1:0]         tap_cnt_d;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] mult_res_q;
    logic                     s1_valid_q;
    logic                     s1_first_q;
    logic                     s1_last_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic                     s2_done_q;
    logic signed [OUT_W-1:0]  scaled;
    logic                     out_valid_q;
    logic signed [OUT_W-1:0]  out_data_q;

    // A held result freezes the whole pipe; out_ready reaches in_ready through one gate.
    assign en       = ~(out_valid_q & ~out_ready);
    assign in_ready = en;
    assign accept   = in_valid & en & ~flush;

    // Stage 0: tap position of the pair being accepted.
    assign tap_first = (tap_cnt_q == '0);
    assign tap_last  = (tap_cnt_q == LAST_TAP);
    assign tap_cnt_d = tap_last ? '0 : tap_cnt_q + 1'b1;

    // Sign-extend both operands so the product is exact in PROD_W bits.
    assign prod = PROD_W'(din) * PROD_W'(coef);

    // Running sum including the product currently in stage 1.
    assign acc_d = s1_first_q ? ACC_W'(mult_res_q) : acc_q + ACC_W'(mult_res_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap_cnt_q  <= '0;
            mult_res_q <= '0;
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            acc_q      <= '0;
            s2_done_q  <= 1'b0;
        end else if (flush) begin
            // Abort everything in flight; the pair offered this cycle is discarded.
            tap_cnt_q  <= '0;
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            s2_done_q  <= 1'b0;
        end else if (en) begin
            s1_valid_q <= accept;
            if (accept) begin
                tap_cnt_q  <= tap_cnt_d;
                mult_res_q <= prod;
                s1_first_q <= tap_first;
                s1_last_q  <= tap_last;
            end
            if (s1_valid_q) begin
                acc_q <= acc_d;
            end
            // acc_q holds a complete block sum in the cycle s2_done_q is high.
            s2_done_q <= s1_valid_q & s1_last_q;
        end
    end

    dct_round_sat #(
        .IN_W   (ACC_W),
        .OUT_W  (OUT_W),
        .FRAC   (FRAC),
        .SAT_EN (SAT_EN)
    ) u_round_sat (
        .sum_i (acc_q),
        .res_o (scaled)
    );

    // en already implies the register is empty or draining this cycle.
    assign load = s2_done_q & en & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= scaled;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (tap_cnt_q != '0) | s1_valid_q | s2_done_q;

endmodule
